// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, types and helpers for the instruction fetch unit
package inst_fetch_pkg;

    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        ChipDisable    = 1'b0;
    localparam logic        RstEnable      = 1'b1;
    localparam int          InstFetchDepth = 2;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - prefetch queue of {pc, inst} pairs with clear overriding push/pop
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = InstFetchDepth,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [31:0]   push_pc_i,
    input  logic [31:0]   push_inst_i,
    output logic [31:0]   head_pc_o,
    output logic [31:0]   head_inst_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push_i && (count_q != FullCount);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: ZeroWord, inst: ZeroWord};
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head_pc_o   = mem_q[rd_ptr_q].pc;
    assign head_inst_o = mem_q[rd_ptr_q].inst;
    assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC generation, ROM access and redirect handling feeding the prefetch queue
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = InstFetchDepth
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    inst_addr_t    pc_q;
    inst_addr_t    pc_d;
    logic [CW-1:0] fifo_count;
    logic          fetch_en;
    logic          redirect;
    logic          push;
    logic          pop;

    // Fetch enable depends only on registered state so ce/addr never see late pipeline inputs.
    assign fetch_en = (state_q == ST_FETCH) && (fifo_count < FullCount);
    assign redirect = flush || branch_flag;
    assign push     = fetch_en && !redirect;
    assign pop      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // flush outranks branch; a redirect drops the ROM word read this cycle.
    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = word_align(flush_pc);
        end else if (branch_flag) begin
            pc_d = word_align(branch_target);
        end else if (fetch_en) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (redirect),
        .push_pc_i   (pc_q),
        .push_inst_i (rom_inst),
        .head_pc_o   (out_pc),
        .head_inst_o (out_inst),
        .count_o     (fifo_count)
    );

    assign rom_ce    = fetch_en ? ChipEnable : ChipDisable;
    assign rom_addr  = pc_q;
    assign out_valid = (fifo_count != '0);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with directed vectors
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic        w_rom_ce;
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_inst;
    logic        w_branch_flag;
    logic [31:0] w_branch_target;
    logic        w_flush;
    logic [31:0] w_flush_pc;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_inst;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] mon_pc;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign rom_inst   = rom_model(rom_addr);
    assign w_rom_inst = rom_model(w_rom_addr);

    inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .flush_pc(flush_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .rom_ce(w_rom_ce), .rom_addr(w_rom_addr), .rom_inst(w_rom_inst),
        .branch_flag(w_branch_flag), .branch_target(w_branch_target),
        .flush(w_flush), .flush_pc(w_flush_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_inst(w_out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake outside reset/redirect must match the scoreboard head.
    always @(negedge clk) begin
        if (rst == 1'b0 && !flush && !branch_flag && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%h expected=none", out_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                chk("pop_pc", out_pc, mon_pc);
                chk("pop_inst", out_inst, rom_model(mon_pc));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        out_ready = 1'b0;
        branch_flag = 1'b0;
        branch_target = '0;
        flush = 1'b0;
        flush_pc = '0;
        w_out_ready = 1'b1;
        w_branch_flag = 1'b0;
        w_branch_target = '0;
        w_flush = 1'b0;
        w_flush_pc = '0;
        repeat (3) step();

        chk("rst_ce", {31'b0, rom_ce}, 32'h0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("w_rst_addr", w_rom_addr, 32'hFFFF_FFF8);

        // Streaming with out_ready high: 0..20 delivered before ready drops.
        for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
        rst = 1'b0;
        out_ready = 1'b1;
        chk("idle_ce", {31'b0, rom_ce}, 32'h0);
        chk("w_idle_ce", {31'b0, w_rom_ce}, 32'h0);
        step();
        chk("t1_ce", {31'b0, rom_ce}, 32'h1);
        chk("t1_addr", rom_addr, 32'h0);
        chk("t1_valid", {31'b0, out_valid}, 32'h0);
        chk("w_t1_addr", w_rom_addr, 32'hFFFF_FFF8);
        step();
        chk("t2_addr", rom_addr, 32'h4);
        chk("t2_valid", {31'b0, out_valid}, 32'h1);
        chk("w_t2_addr", w_rom_addr, 32'hFFFF_FFFC);
        chk("w_t2_pc", w_out_pc, 32'hFFFF_FFF8);
        chk("w_t2_inst", w_out_inst, 32'h4FFF_FFFE);
        step();
        chk("w_t3_addr", w_rom_addr, 32'h0);
        chk("w_t3_pc", w_out_pc, 32'hFFFF_FFFC);
        step();
        chk("w_t4_addr", w_rom_addr, 32'h4);
        repeat (4) step();
        out_ready = 1'b0;
        chk("t8_addr", rom_addr, 32'h1C);
        chk("t8_ce", {31'b0, rom_ce}, 32'h1);
        step();
        chk("t9_full_ce", {31'b0, rom_ce}, 32'h0);
        chk("t9_addr", rom_addr, 32'h20);
        chk("t9_head", out_pc, 32'h18);

        // One-cycle reset while the queue holds two entries.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", {31'b0, out_valid}, 32'h0);
        chk("mr_ce", {31'b0, rom_ce}, 32'h0);
        chk("mr_addr", rom_addr, 32'h0);
        chk("mr_out_pc", out_pc, 32'h0);
        step();
        chk("mr_restart_ce", {31'b0, rom_ce}, 32'h1);
        chk("mr_restart_addr", rom_addr, 32'h0);

        // Back-pressure: two fetches then ce low with addr held at 8.
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        step();
        chk("bp_u2_addr", rom_addr, 32'h4);
        step();
        chk("bp_full_ce", {31'b0, rom_ce}, 32'h0);
        chk("bp_full_addr", rom_addr, 32'h8);
        chk("bp_head", out_pc, 32'h0);
        repeat (3) step();
        chk("bp_hold_ce", {31'b0, rom_ce}, 32'h0);
        chk("bp_hold_addr", rom_addr, 32'h8);
        out_ready = 1'b1;
        step();
        chk("bp_reen_ce", {31'b0, rom_ce}, 32'h1);
        chk("bp_reen_addr", rom_addr, 32'h8);
        repeat (2) step();
        out_ready = 1'b0;
        chk("bp_u9_head", out_pc, 32'hC);
        step();
        chk("bp_u10_ce", {31'b0, rom_ce}, 32'h0);
        chk("bp_u10_addr", rom_addr, 32'h14);

        // Branch while full: target low bits dropped, queue emptied.
        branch_flag = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_flag = 1'b0;
        chk("br_valid", {31'b0, out_valid}, 32'h0);
        chk("br_addr", rom_addr, 32'h100);
        chk("br_ce", {31'b0, rom_ce}, 32'h1);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        out_ready = 1'b1;
        repeat (3) step();

        // Flush and branch together: flush vector wins.
        flush = 1'b1;
        flush_pc = 32'h0000_0020;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0040;
        step();
        flush = 1'b0;
        branch_flag = 1'b0;
        chk("fl_addr", rom_addr, 32'h20);
        chk("fl_ce", {31'b0, rom_ce}, 32'h1);
        chk("fl_valid", {31'b0, out_valid}, 32'h0);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        repeat (3) step();
        out_ready = 1'b0;
        repeat (3) step();
        chk("scoreboard_left", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
